// File: rtl/ddr3_pkg.sv
// Shared DDR3 command encoding used by the bank FSMs, the arbiter and the
// command generator.
package ddr3_pkg;

    typedef enum logic [2:0] {
        CMD_NOP       = 3'd0,
        CMD_ACTIVATE  = 3'd1,
        CMD_READ      = 3'd2,
        CMD_WRITE     = 3'd3,
        CMD_PRECHARGE = 3'd4
    } ddr3_cmd_t;

endpackage

// File: rtl/ddr3_cmd_arbiter_if.sv
// Bundle between the per-bank requesters, the command arbiter and the
// downstream DDR3 command generator.
interface ddr3_cmd_arbiter_if #(
    parameter int NUM_BANKS  = 8,
    parameter int ADDR_WIDTH = 14
);
    import ddr3_pkg::*;

    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    logic [NUM_BANKS-1:0]                 bank_cmd_valid;
    ddr3_cmd_t [NUM_BANKS-1:0]            bank_cmd_type;
    logic [NUM_BANKS-1:0][ADDR_WIDTH-1:0] bank_cmd_addr;
    logic [NUM_BANKS-1:0]                 bank_cmd_grant;

    logic                                 out_cmd_valid;
    ddr3_cmd_t                            out_cmd_type;
    logic [BANK_W-1:0]                    out_cmd_bank;
    logic [ADDR_WIDTH-1:0]                out_cmd_addr;

    // Requester / consumer side (bank FSMs and command generator).
    modport master (
        output bank_cmd_valid, bank_cmd_type, bank_cmd_addr,
        input  bank_cmd_grant,
        input  out_cmd_valid, out_cmd_type, out_cmd_bank, out_cmd_addr
    );

    // Arbiter side.
    modport slave (
        input  bank_cmd_valid, bank_cmd_type, bank_cmd_addr,
        output bank_cmd_grant,
        output out_cmd_valid, out_cmd_type, out_cmd_bank, out_cmd_addr
    );

endinterface

// File: rtl/ddr3_cmd_arbiter.sv
// Round-robin arbiter for the shared DDR3 command bus. Each bank FSM posts one
// command; the arbiter grants at most one per cycle, honouring tRRD (ACT to
// ACT), tCCD (column to column) and tFAW (four-activate window), and registers
// the granted command towards the command generator.
module ddr3_cmd_arbiter
    import ddr3_pkg::*;
#(
    parameter int NUM_BANKS  = 8,
    parameter int TRRD       = 4,
    parameter int TCCD       = 4,
    parameter int TFAW       = 20,
    parameter int ADDR_WIDTH = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    ddr3_cmd_arbiter_if.slave  bus
);

    localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int MAX_T_A   = (TRRD > TCCD) ? TRRD : TCCD;
    localparam int MAX_T     = (MAX_T_A > TFAW) ? MAX_T_A : TFAW;
    localparam int CNT_W     = $clog2(MAX_T + 1);
    localparam int FAW_SLOTS = 4;

    logic [BANK_W-1:0]                rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]                 trrd_cnt_q, trrd_cnt_d;
    logic [CNT_W-1:0]                 tccd_cnt_q, tccd_cnt_d;
    logic [FAW_SLOTS-1:0][CNT_W-1:0]  faw_cnt_q, faw_cnt_d;
    logic                             out_valid_q, out_valid_d;
    ddr3_cmd_t                        out_type_q, out_type_d;
    logic [BANK_W-1:0]                out_bank_q, out_bank_d;
    logic [ADDR_WIDTH-1:0]            out_addr_q, out_addr_d;

    logic [FAW_SLOTS-1:0]             faw_busy_s;
    logic                             faw_full_s;
    logic [NUM_BANKS-1:0]             eligible_s;
    logic                             grant_found_s;
    logic [BANK_W-1:0]                grant_idx_s;
    ddr3_cmd_t                        grant_type_s;
    logic [ADDR_WIDTH-1:0]            grant_addr_s;
    logic                             grant_act_s;
    logic                             grant_col_s;

    // Decide which requesters may issue this cycle under the timing windows.
    always_comb begin
        for (int s = 0; s < FAW_SLOTS; s++) begin
            faw_busy_s[s] = (faw_cnt_q[s] != {CNT_W{1'b0}});
        end
        faw_full_s = &faw_busy_s;
        for (int i = 0; i < NUM_BANKS; i++) begin
            case (bus.bank_cmd_type[i])
                CMD_ACTIVATE:  eligible_s[i] = (trrd_cnt_q == {CNT_W{1'b0}}) && !faw_full_s;
                CMD_READ,
                CMD_WRITE:     eligible_s[i] = (tccd_cnt_q == {CNT_W{1'b0}});
                CMD_PRECHARGE: eligible_s[i] = 1'b1;
                default:       eligible_s[i] = 1'b0;
            endcase
            // Requests are ignored entirely while reset is held.
            eligible_s[i] = eligible_s[i] && bus.bank_cmd_valid[i] && rst_n;
        end
    end

    // Pick the first eligible requester at or after the round-robin pointer.
    always_comb begin
        int cand;
        grant_found_s = 1'b0;
        grant_idx_s   = {BANK_W{1'b0}};
        cand          = 0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_BANKS) begin
                cand = cand - NUM_BANKS;
            end else begin
                cand = cand;
            end
            if (!grant_found_s && eligible_s[cand]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = BANK_W'(cand);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
        grant_type_s = bus.bank_cmd_type[grant_idx_s];
        grant_addr_s = bus.bank_cmd_addr[grant_idx_s];
        grant_act_s  = grant_found_s && (grant_type_s == CMD_ACTIVATE);
        grant_col_s  = grant_found_s && ((grant_type_s == CMD_READ) || (grant_type_s == CMD_WRITE));
    end

    // One-hot grant back to the winning bank FSM in the selection cycle.
    always_comb begin
        bus.bank_cmd_grant = {NUM_BANKS{1'b0}};
        if (grant_found_s) begin
            bus.bank_cmd_grant[grant_idx_s] = 1'b1;
        end else begin
            bus.bank_cmd_grant = {NUM_BANKS{1'b0}};
        end
    end

    // Next-state for pointer, timing counters and the registered output command.
    always_comb begin
        logic faw_loaded;
        if (grant_found_s) begin
            rr_ptr_d = (grant_idx_s == BANK_W'(NUM_BANKS - 1)) ? {BANK_W{1'b0}}
                                                               : grant_idx_s + BANK_W'(1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end

        if (grant_act_s) begin
            trrd_cnt_d = CNT_W'(TRRD - 1);
        end else if (trrd_cnt_q != {CNT_W{1'b0}}) begin
            trrd_cnt_d = trrd_cnt_q - CNT_W'(1);
        end else begin
            trrd_cnt_d = trrd_cnt_q;
        end

        if (grant_col_s) begin
            tccd_cnt_d = CNT_W'(TCCD - 1);
        end else if (tccd_cnt_q != {CNT_W{1'b0}}) begin
            tccd_cnt_d = tccd_cnt_q - CNT_W'(1);
        end else begin
            tccd_cnt_d = tccd_cnt_q;
        end

        // An ACTIVATE claims the lowest idle slot; busy slots count down.
        faw_loaded = 1'b0;
        for (int s = 0; s < FAW_SLOTS; s++) begin
            if (grant_act_s && !faw_loaded && !faw_busy_s[s]) begin
                faw_cnt_d[s] = CNT_W'(TFAW - 1);
                faw_loaded   = 1'b1;
            end else if (faw_busy_s[s]) begin
                faw_cnt_d[s] = faw_cnt_q[s] - CNT_W'(1);
            end else begin
                faw_cnt_d[s] = faw_cnt_q[s];
            end
        end

        if (grant_found_s) begin
            out_valid_d = 1'b1;
            out_type_d  = grant_type_s;
            out_bank_d  = grant_idx_s;
            out_addr_d  = grant_addr_s;
        end else begin
            out_valid_d = 1'b0;
            out_type_d  = CMD_NOP;
            out_bank_d  = {BANK_W{1'b0}};
            out_addr_d  = {ADDR_WIDTH{1'b0}};
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= {BANK_W{1'b0}};
            trrd_cnt_q  <= {CNT_W{1'b0}};
            tccd_cnt_q  <= {CNT_W{1'b0}};
            faw_cnt_q   <= {(FAW_SLOTS*CNT_W){1'b0}};
            out_valid_q <= 1'b0;
            out_type_q  <= CMD_NOP;
            out_bank_q  <= {BANK_W{1'b0}};
            out_addr_q  <= {ADDR_WIDTH{1'b0}};
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            trrd_cnt_q  <= trrd_cnt_d;
            tccd_cnt_q  <= tccd_cnt_d;
            faw_cnt_q   <= faw_cnt_d;
            out_valid_q <= out_valid_d;
            out_type_q  <= out_type_d;
            out_bank_q  <= out_bank_d;
            out_addr_q  <= out_addr_d;
        end
    end

    assign bus.out_cmd_valid = out_valid_q;
    assign bus.out_cmd_type  = out_type_q;
    assign bus.out_cmd_bank  = out_bank_q;
    assign bus.out_cmd_addr  = out_addr_q;

endmodule

// File: tb/tb_ddr3_cmd_arbiter.sv
// Scoreboard bench for ddr3_cmd_arbiter: directed timing scenarios followed by
// randomized bank traffic checked against a time-stamp based reference model.
`timescale 1ns/1ps
module tb_ddr3_cmd_arbiter;
    import ddr3_pkg::*;

    localparam int NB   = 8;
    localparam int AW   = 14;
    localparam int TRRD = 4;
    localparam int TCCD = 4;
    localparam int TFAW = 20;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ddr3_cmd_arbiter_if #(.NUM_BANKS(NB), .ADDR_WIDTH(AW)) bif ();

    ddr3_cmd_arbiter #(
        .NUM_BANKS(NB), .TRRD(TRRD), .TCCD(TCCD), .TFAW(TFAW), .ADDR_WIDTH(AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    typedef struct {
        ddr3_cmd_t      t;
        int             b;
        logic [AW-1:0]  a;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Bank requester state driven onto the bus each cycle.
    logic           req_v[NB];
    ddr3_cmd_t      req_t[NB];
    logic [AW-1:0]  req_a[NB];
    bit             keep_req[NB];
    int             grant_cyc[NB];
    int             grant_order[$];

    // Reference model: timestamps of past grants.
    int cyc      = 0;
    int rr       = 0;
    int last_act = -1000;
    int last_col = -1000;
    int act_hist[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        rr       = 0;
        last_act = -1000;
        last_col = -1000;
        act_hist.delete();
    endfunction

    function automatic bit model_elig(input int i);
        int busy;
        busy = 0;
        if (!req_v[i]) return 1'b0;
        case (req_t[i])
            CMD_ACTIVATE: begin
                foreach (act_hist[j]) if (cyc - act_hist[j] < TFAW) busy++;
                return (cyc - last_act >= TRRD) && (busy < 4);
            end
            CMD_READ, CMD_WRITE: return (cyc - last_col >= TCCD);
            CMD_PRECHARGE:       return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    function automatic int model_pick();
        for (int k = 0; k < NB; k++) begin
            if (model_elig((rr + k) % NB)) return (rr + k) % NB;
        end
        return -1;
    endfunction

    task automatic refill_random();
        for (int i = 0; i < NB; i++) begin
            if (!req_v[i]) begin
                if ($urandom_range(99, 0) < 30) begin
                    req_v[i] = 1'b1;
                    req_t[i] = ddr3_cmd_t'($urandom_range(4, 0));
                    req_a[i] = AW'($urandom);
                end
            end else if (req_t[i] == CMD_NOP && $urandom_range(99, 0) < 20) begin
                req_v[i] = 1'b0;
            end
        end
    endtask

    // One arbitration cycle: drive at negedge, check grant, push expectation.
    task automatic step(input bit rst_val, input bit refill);
        int             g;
        int             dut_g;
        logic [NB-1:0]  exp_vec;
        @(negedge clk);
        cyc++;
        rst_n = rst_val;
        for (int i = 0; i < NB; i++) begin
            bif.bank_cmd_valid[i] = req_v[i];
            bif.bank_cmd_type[i]  = req_t[i];
            bif.bank_cmd_addr[i]  = req_a[i];
        end
        #1;
        if (!rst_val) begin
            chk("rst_out_valid", {31'd0, bif.out_cmd_valid}, 32'd0);
            chk("rst_out_type", {29'd0, bif.out_cmd_type}, {29'd0, CMD_NOP});
            chk("rst_out_bank", {29'd0, bif.out_cmd_bank}, 32'd0);
            chk("rst_out_addr", {18'd0, bif.out_cmd_addr}, 32'd0);
            g = -1;
        end else begin
            g = model_pick();
        end
        exp_vec = '0;
        if (g >= 0) exp_vec[g] = 1'b1;
        chk("grant", {24'd0, bif.bank_cmd_grant}, {24'd0, exp_vec});
        dut_g = -1;
        for (int i = 0; i < NB; i++) if (bif.bank_cmd_grant[i]) dut_g = i;
        if (dut_g >= 0) begin
            grant_cyc[dut_g] = cyc;
            grant_order.push_back(dut_g);
        end
        if (g >= 0) begin
            exp_q.push_back('{t: req_t[g], b: g, a: req_a[g]});
            if (req_t[g] == CMD_ACTIVATE) begin
                last_act = cyc;
                act_hist.push_back(cyc);
            end
            if (req_t[g] == CMD_READ || req_t[g] == CMD_WRITE) last_col = cyc;
            rr = (g + 1) % NB;
            if (!keep_req[g]) req_v[g] = 1'b0;
        end
        while (act_hist.size() > 0 && cyc - act_hist[0] >= TFAW) void'(act_hist.pop_front());
        if (!rst_val) model_reset();
        if (refill) refill_random();
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NB; i++) begin
            req_v[i]     = 1'b0;
            req_t[i]     = CMD_NOP;
            req_a[i]     = '0;
            keep_req[i]  = 1'b0;
            grant_cyc[i] = -1000;
        end
        grant_order.delete();
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic set_req(input int b, input ddr3_cmd_t t, input logic [AW-1:0] a);
        req_v[b] = 1'b1;
        req_t[b] = t;
        req_a[b] = a;
    endtask

    // Monitor: each issued command must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bif.out_cmd_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_issue: got bank %0d with no grant pending", bif.out_cmd_bank);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_type", {29'd0, bif.out_cmd_type}, {29'd0, e.t});
                    chk("out_bank", {29'd0, bif.out_cmd_bank}, 32'(e.b));
                    chk("out_addr", {18'd0, bif.out_cmd_addr}, {18'd0, e.a});
                end
            end else begin
                chk("idle_type", {29'd0, bif.out_cmd_type}, {29'd0, CMD_NOP});
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_issue: got no command expected bank %0d", e.b);
                end
            end
        end
    end

    initial begin
        int n;
        int exp29[6];
        int exp32[5];
        exp29 = '{0, 3, 5, 0, 3, 5};
        exp32 = '{0, 4, 8, 12, 20};
        rst_n = 1'b0;
        bif.bank_cmd_valid = '0;
        for (int i = 0; i < NB; i++) begin
            bif.bank_cmd_type[i] = CMD_NOP;
            bif.bank_cmd_addr[i] = '0;
        end
        clear_reqs();
        do_reset();

        // Single ACTIVATE after reset.
        set_req(2, CMD_ACTIVATE, 14'h100);
        n = cyc + 1;
        step(1'b1, 1'b0);
        chk("r028_grant_cycle", 32'(grant_cyc[2] - n), 32'd0);
        repeat (3) step(1'b1, 1'b0);

        // Continuous PRECHARGE round-robin.
        do_reset();
        clear_reqs();
        foreach (exp29[k]) begin
            if (k < 3) begin
                set_req(exp29[k], CMD_PRECHARGE, AW'(exp29[k] + 7));
                keep_req[exp29[k]] = 1'b1;
            end
        end
        repeat (6) step(1'b1, 1'b0);
        chk("r029_count", 32'(grant_order.size()), 32'd6);
        for (int k = 0; k < 6 && k < grant_order.size(); k++) chk("r029_order", 32'(grant_order[k]), 32'(exp29[k]));
        clear_reqs();
        step(1'b1, 1'b0);

        // tRRD with a PRECHARGE slipping past a blocked ACTIVATE.
        do_reset();
        clear_reqs();
        set_req(0, CMD_ACTIVATE, 14'h011);
        set_req(1, CMD_ACTIVATE, 14'h022);
        n = cyc + 1;
        step(1'b1, 1'b0);
        set_req(4, CMD_PRECHARGE, 14'h044);
        repeat (6) step(1'b1, 1'b0);
        chk("r030_bank0", 32'(grant_cyc[0] - n), 32'd0);
        chk("r030_bank4", 32'(grant_cyc[4] - n), 32'd1);
        chk("r030_bank1", 32'(grant_cyc[1] - n), 32'd4);

        // tCCD between two READs.
        do_reset();
        clear_reqs();
        set_req(1, CMD_READ, 14'h0A1);
        set_req(2, CMD_READ, 14'h0A2);
        n = cyc + 1;
        repeat (7) step(1'b1, 1'b0);
        chk("r031_bank1", 32'(grant_cyc[1] - n), 32'd0);
        chk("r031_bank2", 32'(grant_cyc[2] - n), 32'd4);

        // tFAW with five simultaneous ACTIVATEs.
        do_reset();
        clear_reqs();
        for (int b = 0; b < 5; b++) set_req(b, CMD_ACTIVATE, AW'(14'h200 + b));
        n = cyc + 1;
        repeat (23) step(1'b1, 1'b0);
        for (int b = 0; b < 5; b++) chk("r032_act", 32'(grant_cyc[b] - n), 32'(exp32[b]));

        // Reset in the middle of the activate window.
        do_reset();
        clear_reqs();
        for (int b = 0; b < 5; b++) set_req(b, CMD_ACTIVATE, AW'(14'h300 + b));
        n = cyc + 1;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("r033_pre_bank0", 32'(grant_cyc[0] - n), 32'd0);
        do_reset();
        for (int b = 0; b < 5; b++) set_req(b, CMD_ACTIVATE, AW'(14'h300 + b));
        n = cyc + 1;
        step(1'b1, 1'b0);
        chk("r033_post_bank0", 32'(grant_cyc[0] - n), 32'd0);
        repeat (4) step(1'b1, 1'b0);
        chk("r033_post_bank1", 32'(grant_cyc[1] - n), 32'd4);

        // Randomized traffic with occasional resets.
        do_reset();
        clear_reqs();
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(399, 0) == 0) ? 1'b0 : 1'b1, 1'b1);
        end

        clear_reqs();
        repeat (3) step(1'b1, 1'b0);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
